wb_initiator: RTL and testbench

Wishbone classic single-transfer bus initiator: the master end of the `cyc`/`stb`/`we`/`ack` interface that the controller's core memory port responds to. It turns a valid/ready request from a core-side wrapper or test harness into one Wishbone cycle. It holds the result in a valid/ready response register until the client accepts it. An optional watchdog aborts cycles that never receive `ack`.

---
 rtl/wb_initiator_if.sv | 36 +++
 rtl/wb_initiator.sv | 139 +++++++++++++
 tb/tb_wb_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_initiator_if.sv
// Client request/response and Wishbone master signals of wb_initiator in one bundle.
// master: the initiator's view; slave: the client plus responder view used by a harness.
interface wb_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_data_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  rsp_err_o;
    logic                  busy_o;
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  ack_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i, data_i, ack_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
               cyc_o, stb_o, we_o, addr_o, data_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i, data_i, ack_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
               cyc_o, stb_o, we_o, addr_o, data_o
    );
endinterface

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator; WB_TIMEOUT_EN adds an ack watchdog abort.
// Latency: accept to rsp_valid_o >= 2 cycles; at most one transfer every 3 cycles.
// Backpressure: req_ready_o stays low until the held response is taken with rsp_ready_i.
module wb_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    wb_initiator_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_RESP = 2'b10
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_launch;
    logic                  w_finish;
    logic                  w_abort;
    logic                  w_tmo_hit;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_data;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_err;

    // Fires in the last allowed BUS cycle, so stb_o is high for exactly TIMEOUT_CYCLES.
    assign w_tmo_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_launch) begin
                r_cnt <= '0;
            end else if (r_state == S_BUS && !bus.ack_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_rsp_err <= 1'b0;
            end else if (w_abort) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign bus.rsp_err_o = r_rsp_err;
`else
    assign w_tmo_hit     = 1'b0;
    assign bus.rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ack has priority over the watchdog when both land in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    w_next_state = S_BUS;
                    w_launch     = 1'b1;
                end
            end
            S_BUS: begin
                if (bus.ack_i) begin
                    w_next_state = S_RESP;
                    w_finish     = 1'b1;
                end else if (w_tmo_hit) begin
                    w_next_state = S_RESP;
                    w_abort      = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_launch) begin
                r_we    <= bus.req_we_i;
                r_addr  <= bus.req_addr_i;
                r_wdata <= bus.req_data_i;
            end
            if (w_finish) begin
                r_rsp_data <= r_we ? '0 : bus.data_i;
            end else if (w_abort) begin
                r_rsp_data <= '0;
            end
        end
    end

    assign bus.req_ready_o = (r_state == S_IDLE);
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.cyc_o       = (r_state == S_BUS);
    assign bus.stb_o       = (r_state == S_BUS);
    assign bus.rsp_valid_o = (r_state == S_RESP);
    assign bus.we_o        = r_we;
    assign bus.addr_o      = r_addr;
    assign bus.data_o      = r_wdata;
    assign bus.rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized scoreboard bench for wb_initiator: a memory-backed responder and a reference
// model predict bus activity and responses; timeout cases run only with WB_TIMEOUT_EN.
module tb_wb_initiator;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          w;
        int          cycles;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        bit          err;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst;

    wb_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_initiator #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;
    int rdy_mode    = 0;
    bit rst_abort   = 1'b0;

    bus_exp_t    exp_bus_q[$];
    rsp_exp_t    exp_rsp_q[$];
    logic [31:0] mdl_mem[logic [31:0]];
    logic [31:0] sl_mem[logic [31:0]];

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        vectors++;
        miscompares++;
        $display("FAIL %s: still waiting after %0d cycles", name, waited);
    endtask

    // Reference model: decides the outcome of a transfer from its wait count alone.
    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input int w, input bit push_rsp = 1'b1);
        bus_exp_t b;
        rsp_exp_t r;
        bit       to;
        int       n;
        to = 1'b0;
`ifdef WB_TIMEOUT_EN
        to = (w >= TMO);
`endif
        b.we     = we;
        b.addr   = addr;
        b.data   = data;
        b.w      = w;
        b.cycles = to ? TMO : w + 1;
        r.err    = to;
        if (to || we) r.data = 32'h0;
        else          r.data = mdl_mem.exists(addr) ? mdl_mem[addr] : dflt(addr);
        if (we && !to) mdl_mem[addr] = data;
        exp_bus_q.push_back(b);
        if (push_rsp) exp_rsp_q.push_back(r);

        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_data_i  = data;
        n = 0;
        while (!bus.req_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) bound_fail("req_accept", n);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || bus.busy_o) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) bound_fail("drain", n);
    endtask

    // Response ready driver.
    initial begin
        bus.rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.rsp_ready_i = 1'b0;
                2:       bus.rsp_ready_i = 1'b1;
                default: bus.rsp_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Memory-backed Wishbone responder; also checks bus signals each BUS cycle.
    bus_exp_t rs_cur;
    int       rs_cnt  = 0;
    bit       rs_in   = 1'b0;
    bit       rs_spur = 1'b0;

    initial begin
        bus.ack_i  = 1'b0;
        bus.data_i = '0;
        forever begin
            @(negedge clk);
            bus.ack_i = 1'b0;
            if (rs_spur) begin
                bus.ack_i = 1'b1;
                rs_spur   = 1'b0;
            end
            if (!rs_in && bus.stb_o) begin
                if (exp_bus_q.size() == 0) begin
                    bound_fail("bus_unexpected_cycle", 0);
                    rs_cur.w      = 1000;
                    rs_cur.cycles = 0;
                end else begin
                    rs_cur = exp_bus_q.pop_front();
                end
                rs_in  = 1'b1;
                rs_cnt = 0;
            end
            if (rs_in) begin
                if (bus.stb_o) begin
                    rs_cnt++;
                    chk("cyc_o", 64'(bus.cyc_o), 64'd1);
                    chk("we_o", 64'(bus.we_o), 64'(rs_cur.we));
                    chk("addr_o", 64'(bus.addr_o), 64'(rs_cur.addr));
                    chk("data_o", 64'(bus.data_o), 64'(rs_cur.data));
                    if (rs_cnt == rs_cur.w + 1) begin
                        bus.ack_i = 1'b1;
                        if (rs_cur.we) begin
                            sl_mem[rs_cur.addr] = bus.data_o;
                            bus.data_i = $urandom;
                        end else begin
                            bus.data_i = sl_mem.exists(rs_cur.addr) ? sl_mem[rs_cur.addr]
                                                                    : dflt(rs_cur.addr);
                        end
                        rs_spur = ($urandom_range(0, 3) == 0);
                    end else begin
                        bus.data_i = $urandom;
                    end
                end else begin
                    if (!rst_abort) chk("stb_cycles", 64'(rs_cnt), 64'(rs_cur.cycles));
                    rst_abort = 1'b0;
                    rs_in     = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard when a response appears, checks it while held.
    rsp_exp_t mn_cur;
    bit       mn_have = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mn_have = 1'b0;
        end else if (bus.rsp_valid_o) begin
            if (!mn_have) begin
                if (exp_rsp_q.size() == 0) begin
                    bound_fail("rsp_unexpected", 0);
                end else begin
                    mn_cur  = exp_rsp_q.pop_front();
                    mn_have = 1'b1;
                end
            end
            if (mn_have) begin
                chk("rsp_data_o", 64'(bus.rsp_data_o), 64'(mn_cur.data));
                chk("rsp_err_o", 64'(bus.rsp_err_o), 64'(mn_cur.err));
                chk("req_ready_in_resp", 64'(bus.req_ready_o), 64'd0);
            end
            if (bus.rsp_ready_i) mn_have = 1'b0;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        int w;
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        mdl_mem[32'h10] = 32'hCAFE_F00D;
        sl_mem[32'h10]  = 32'hCAFE_F00D;

        #3;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_cyc", 64'(bus.cyc_o), 64'd0);
        chk("rst_stb", 64'(bus.stb_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err_o), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Zero-wait read, wait-state write, read-back of the written word.
        send(1'b0, 32'h0000_0010, $urandom, 0);
        send(1'b1, 32'h0000_0100, 32'h1234_5678, 3);
        send(1'b0, 32'h0000_0100, $urandom, 1);
        drain();

        // Response backpressure with the next request already pending.
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send(1'b0, 32'h0000_0020, $urandom, 0);
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) bound_fail("bp_rsp_valid_wait", n);
        fork
            send(1'b0, 32'h0000_0024, $urandom, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
                    chk("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
                end
                rdy_mode = 2;
                @(posedge clk);
                #2;
                k = cyc_n;
                n = 0;
                @(negedge clk);
                while (!bus.stb_o && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_launch_delay", 64'(cyc_n - k), 64'd2);
            end
        join
        rdy_mode = 0;
        drain();

`ifdef WB_TIMEOUT_EN
        send(1'b0, 32'h0000_0030, $urandom, 1000);
        send(1'b1, 32'h0000_0034, 32'hDEAD_BEEF, TMO - 1);
        send(1'b0, 32'h0000_0034, $urandom, 0);
        drain();
`endif

        // Reset while a cycle is outstanding.
        rst_abort = 1'b1;
        send(1'b0, 32'h0000_0040, $urandom, 1000, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_cyc", 64'(bus.cyc_o), 64'd0);
        chk("midrst_stb", 64'(bus.stb_o), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("postrst_busy", 64'(bus.busy_o), 64'd0);
        chk("postrst_req_ready", 64'(bus.req_ready_o), 64'd1);
        send(1'b0, 32'h0000_0040, $urandom, 2);
        drain();

        for (int i = 0; i < 150; i++) begin
`ifdef WB_TIMEOUT_EN
            w = int'($urandom_range(0, TMO + 2));
`else
            w = int'($urandom_range(0, 3));
`endif
            send(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, w);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
